morse_transmitter: RTL and testbench
====================================

MORSE_TRANSMITTER -- requirements
Module: morse_transmitter

Interface
REQ-001 Parameter WIDTH, default 16: number of pattern bits, MSB sent first.
REQ-002 Parameter DIV_W, default 32: width of the rate input and of the symbol-period counter.
REQ-003 Parameter LEN_W, default 5: width of the length input; LEN_W SHALL satisfy 2^LEN_W > WIDTH.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  active-high request, sampled on each rising clock edge.
REQ-007 pattern  in  WIDTH  symbol bits, 1 = mark (on), 0 = space (off); pattern[WIDTH-1] is sent first.
REQ-008 length  in  LEN_W  number of symbols to send from the MSB downward.
REQ-009 rate  in  DIV_W  symbol period minus one, in clock cycles.
REQ-010 repeat  in  1  when high at message end, the captured message is resent.
REQ-011 abort  in  1  synchronous cancel of the current message.
REQ-012 serial_out  out  1  current symbol value.
REQ-013 busy  out  1  high while a message is in progress.
REQ-014 done  out  1  one-cycle pulse on normal message completion.

Function
REQ-015 States SHALL be IDLE and SEND; DONE is signalled by the done pulse, not a held state.
REQ-016 In IDLE, start=1 at edge T SHALL capture pattern, length and rate into internal registers.
REQ-017 If captured length is nonzero, the block SHALL enter SEND with busy=1 from T+1.
REQ-018 Captured length > WIDTH SHALL be clamped to WIDTH.
REQ-019 If captured length is 0, the block SHALL stay in IDLE, pulse done during T+1 only, and keep busy=0 and serial_out=0.
REQ-020 In SEND, serial_out SHALL equal the shift-register MSB, so the first symbol appears at T+1.
REQ-021 Each symbol SHALL be held exactly rate+1 cycles; rate=0 gives one symbol per cycle.
REQ-022 At the end of each symbol period the register SHALL shift left by one with 0 filled in, and the remaining-symbol count SHALL decrement.
REQ-023 After the last symbol period, if repeat=1 on that edge, the captured pattern SHALL be reloaded and sending SHALL continue with no gap cycle; busy stays 1 and done is not pulsed.
REQ-024 After the last symbol period, if repeat=0 on that edge, the block SHALL return to IDLE, with busy=0, serial_out=0, and done=1 for that one cycle.
REQ-025 start while busy=1 SHALL be ignored, and captured values SHALL not change.
REQ-026 Changes on pattern, length or rate during SEND SHALL have no effect.
REQ-027 abort=1 on any edge SHALL force IDLE from the next cycle, with busy=0 and serial_out=0, and SHALL not pulse done.
REQ-028 abort has priority over start and over message completion on the same edge.
REQ-029 start in the same cycle that done is high SHALL be accepted, because the block is already in IDLE.
REQ-030 The symbol-period counter SHALL not wrap within a period; it SHALL reload rate on each symbol boundary.
REQ-031 rate of all-ones is legal and SHALL be handled without overflow.

Reset
REQ-032 aresetn=0 SHALL immediately force IDLE with serial_out=0, busy=0 and done=0, and SHALL clear the shift register, counters and captured values.
REQ-033 Reset mid-message SHALL discard the message; after release the block SHALL wait in IDLE for a new start.
REQ-034 Release of reset SHALL be followed by at least one idle cycle before a start is honoured.

Verification
REQ-035 WIDTH=16, pattern=16'hB800, length=5, rate=2, start pulse, repeat=0 -> serial_out 1,0,1,1,1, each symbol held 3 cycles; busy high for 15 cycles; done pulse in cycle 16.
REQ-036 length=0, start pulse -> done in next cycle only; busy and serial_out stay 0.
REQ-037 length=20, WIDTH=16, rate=0 -> exactly 16 symbols sent, then done.
REQ-038 repeat=1, pattern=16'hA000, length=3, rate=0 -> serial_out 1,0,1,1,0,1,... continuous with no done; drop repeat -> done after the current pass.
REQ-039 abort in the 4th cycle of a message -> busy=0 and serial_out=0 next cycle, no done; a start on the following cycle is accepted.
REQ-040 aresetn low mid-message, with start held across release -> outputs 0 immediately; first accepted start is one cycle after release; new pattern sent correctly.

Source files
------------

// File: rtl/morse_transmitter.sv
// morse_transmitter: serialises a captured on/off pattern MSB-first, holding each symbol rate+1 cycles,
// with optional repeat, abort and a one-cycle done pulse on normal completion.
module morse_transmitter #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 32,
    parameter int LEN_W = 5
) (
    input  logic             clock,
    input  logic             aresetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [DIV_W-1:0] rate,
    input  logic             repeat_en,
    input  logic             abort,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   shreg, shreg_d, pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d, rem, rem_d, len_c;
    logic [DIV_W-1:0]   rate_q, rate_d, cnt, cnt_d;
    logic               done_q, done_d, armed;

    assign len_c      = (length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : length;
    assign busy       = (state == SEND);
    assign serial_out = busy & shreg[WIDTH-1];
    assign done       = done_q;

    // cnt counts down to zero, so an all-ones rate never overflows
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        rem_d   = rem;
        pat_d   = pat_q;
        len_d   = len_q;
        rate_d  = rate_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            shreg_d = '0;
        end else if (state == IDLE) begin
            if (start && armed) begin
                pat_d   = pattern;
                len_d   = len_c;
                rate_d  = rate;
                shreg_d = pattern;
                cnt_d   = rate;
                rem_d   = len_c;
                state_d = (len_c != '0) ? SEND : IDLE;
                done_d  = (len_c == '0);
            end
        end else if (cnt != '0) begin
            cnt_d = cnt - DIV_W'(1);
        end else if (rem > LEN_W'(1)) begin
            shreg_d = {shreg[WIDTH-2:0], 1'b0};
            rem_d   = rem - LEN_W'(1);
            cnt_d   = rate_q;
        end else if (repeat_en) begin
            shreg_d = pat_q;
            rem_d   = len_q;
            cnt_d   = rate_q;
        end else begin
            state_d = IDLE;
            shreg_d = '0;
            rem_d   = '0;
            done_d  = 1'b1;
        end
    end

    // armed holds off start for the first edge after reset release
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            rem    <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            rate_q <= '0;
            done_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            cnt    <= cnt_d;
            rem    <= rem_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            rate_q <= rate_d;
            done_q <= done_d;
            armed  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_morse_transmitter.sv
// tb_morse_transmitter: directed and randomized messages checked against a symbol-list model
// built from pattern/length/rate; inputs driven and outputs sampled on the falling edge.
module tb_morse_transmitter;
    logic        clock = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  length = '0;
    logic [31:0] rate = '0;
    logic        repeat_en = 1'b0;
    logic        abort = 1'b0;
    logic        serial_out, busy, done;
    int          n_cmp = 0;
    int          n_bad = 0;

    morse_transmitter dut (
        .clock(clock), .aresetn(aresetn), .start(start), .pattern(pattern),
        .length(length), .rate(rate), .repeat_en(repeat_en), .abort(abort),
        .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag, input logic exp_done);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".serial"}, serial_out, 0);
        check({tag, ".done"}, done, exp_done);
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle with start low.
    task automatic send_check(input logic [15:0] pat, input int len, input int rt, input string tag);
        logic exp_q[$];
        int   n = (len > 16) ? 16 : len;
        for (int i = 0; i < n; i++)
            for (int r = 0; r <= rt; r++) exp_q.push_back(pat[15-i]);
        start = 1'b1; pattern = pat; length = 5'(len); rate = 32'(rt);
        @(negedge clock);
        foreach (exp_q[k]) begin
            check({tag, ".sym"}, serial_out, exp_q[k]);
            check({tag, ".busy"}, busy, 1);
            check({tag, ".nodone"}, done, 0);
            start = 1'($urandom_range(0, 1));
            pattern = 16'($urandom); length = 5'($urandom); rate = $urandom_range(0, 7);
            @(negedge clock);
        end
        idle_check({tag, ".end"}, 1'b1);
        start = 1'b0;
    endtask

    initial begin
        #1 idle_check("reset", 1'b0);
        start = 1'b1; pattern = 16'hFFFF; length = 5'd4;
        @(negedge clock);
        aresetn = 1'b1;
        @(negedge clock);
        idle_check("first_edge_ignored", 1'b0);
        start = 1'b0;
        @(negedge clock);

        send_check(16'hB800, 5, 2, "basic");
        send_check(16'h1234, 0, 3, "len0");
        send_check(16'hC3A5, 20, 0, "clamp");
        @(negedge clock);
        idle_check("after_done", 1'b0);

        for (int i = 0; i < 8; i++)
            send_check(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), "rand");

        // repeat: three full passes, then drop repeat during the fourth
        repeat_en = 1'b1; start = 1'b1; pattern = 16'hA000; length = 5'd3; rate = 0;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic [15:0] p = 16'hA000;
            check("repeat.sym", serial_out, p[15 - (k % 3)]);
            check("repeat.busy", busy, 1);
            check("repeat.nodone", done, 0);
            if (k == 9) repeat_en = 1'b0;
            @(negedge clock);
        end
        idle_check("repeat.end", 1'b1);

        // abort during the 4th cycle, then a start on the next cycle
        start = 1'b1; pattern = 16'hFFFF; length = 5'd16; rate = 0;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("abort.busy", busy, 1);
            if (k == 3) abort = 1'b1;
            @(negedge clock);
        end
        abort = 1'b0;
        idle_check("abort.end", 1'b0);
        send_check(16'h5A00, 7, 1, "after_abort");

        // all-ones rate holds the first symbol
        start = 1'b1; pattern = 16'h8000; length = 5'd2; rate = '1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check("maxrate.sym", serial_out, 1);
            @(negedge clock);
        end
        check("maxrate.busy", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        idle_check("maxrate.abort", 1'b0);

        // reset mid-message with start held across release
        start = 1'b1; pattern = 16'hF0F0; length = 5'd10; rate = 1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("prereset.busy", busy, 1);
        aresetn = 1'b0;
        #1 idle_check("reset_async", 1'b0);
        @(negedge clock);
        idle_check("reset_held", 1'b0);
        pattern = 16'h9C00; length = 5'd6; rate = 0;
        aresetn = 1'b1;
        @(negedge clock);
        idle_check("release_idle", 1'b0);
        send_check(16'h9C00, 6, 0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
